swc_regfile: RTL and testbench

- RV32I integer register file for the SwitchMCU core.
- It is the responder on the shared regfile bus that the execution units (exu_*_swc) drive through tri-state reg_waddr/reg_wen/reg_wdata and reg_raddr_N/reg_ren_N.
- It provides one write port and two registered read ports, with x0 hardwired to zero, write-to-read bypass and a read-valid strobe per port.
- It sits beside the cycle_cnt sequencer; EXUs assert ren on cycle 1, sample rdata on cycle 3, and write on cycle 4.

---
 rtl/swc_pkg.sv | 10 +
 rtl/swc_regfile_if.sv | 26 ++
 rtl/swc_regfile_rport.sv | 40 ++++
 rtl/swc_regfile.sv | 63 ++++++
 tb/tb_swc_regfile.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/swc_pkg.sv
// Shared constants for the SwitchMCU register file: data/address widths
// and the ABI register indices the core treats specially.
package swc_pkg;
   localparam int                XLEN     = 32;
   localparam int                REG_AW   = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_AW-1:0] REG_RA   = 5'd1;
   localparam logic [REG_AW-1:0] REG_SP   = 5'd2;
   localparam logic [XLEN-1:0]   SP_INIT  = 32'h0000_0000;
endpackage

// File: rtl/swc_regfile_if.sv
// Shared regfile bus: EXUs drive the write port and read requests (master),
// the register file answers with registered read data (slave).
interface swc_regfile_if #(parameter int XLEN = swc_pkg::XLEN) ();
   logic [swc_pkg::REG_AW-1:0] reg_waddr;
   logic                       reg_wen;
   logic [XLEN-1:0]            reg_wdata;
   logic [swc_pkg::REG_AW-1:0] reg_raddr_1;
   logic                       reg_ren_1;
   logic [XLEN-1:0]            reg_rdata_1;
   logic                       reg_rvalid_1;
   logic [swc_pkg::REG_AW-1:0] reg_raddr_2;
   logic                       reg_ren_2;
   logic [XLEN-1:0]            reg_rdata_2;
   logic                       reg_rvalid_2;

   modport master (
      output reg_waddr, reg_wen, reg_wdata,
      output reg_raddr_1, reg_ren_1, reg_raddr_2, reg_ren_2,
      input  reg_rdata_1, reg_rvalid_1, reg_rdata_2, reg_rvalid_2
   );
   modport slave (
      input  reg_waddr, reg_wen, reg_wdata,
      input  reg_raddr_1, reg_ren_1, reg_raddr_2, reg_ren_2,
      output reg_rdata_1, reg_rvalid_1, reg_rdata_2, reg_rvalid_2
   );
endinterface

// File: rtl/swc_regfile_rport.sv
// One registered read port: x0 reads as zero, same-edge writes bypass the
// array, and data is held until the next enabled read.
module swc_regfile_rport #(
   parameter int XLEN = swc_pkg::XLEN
) (
   input  logic                       hclk,
   input  logic                       hrst,
   input  logic                       ren,
   input  logic [swc_pkg::REG_AW-1:0] raddr,
   input  logic [XLEN-1:0]            rfile_data,
   input  logic                       wr_en,
   input  logic [swc_pkg::REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]            wdata,
   output logic [XLEN-1:0]            rdata,
   output logic                       rvalid
);
   import swc_pkg::*;

   logic [XLEN-1:0] val;

   always_comb begin
      val = rfile_data;
      if (raddr == REG_ZERO)
         val = '0;
      else if (wr_en && (waddr == raddr))
         val = wdata;
   end

   // Case equality keeps a floating enable from ever loading data.
   always_ff @(posedge hclk) begin
      if (hrst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= (ren === 1'b1);
         if (ren === 1'b1)
            rdata <= val;
      end
   end
endmodule

// File: rtl/swc_regfile.sv
// RV32I integer register file: one write port, two registered read ports,
// x0 hardwired to zero, x2 reset to SP_INIT.
module swc_regfile #(
   parameter int              NREG    = 32,
   parameter int              XLEN    = swc_pkg::XLEN,
   parameter logic [XLEN-1:0] SP_INIT = swc_pkg::SP_INIT
) (
   input  logic          hclk,
   input  logic          hrst,
   swc_regfile_if.slave  bus
);
   import swc_pkg::*;

   localparam int NPORT = 2;

   logic [XLEN-1:0] regs [NREG];
   logic            wr_en;

   logic [NPORT-1:0]             ren;
   logic [NPORT-1:0][REG_AW-1:0] raddr;
   logic [NPORT-1:0][XLEN-1:0]   rfile_data;
   logic [NPORT-1:0][XLEN-1:0]   rdata;
   logic [NPORT-1:0]             rvalid;

   // The bus is tri-stated between EXU turns, so only a solid 1 writes.
   assign wr_en = (bus.reg_wen === 1'b1) && (bus.reg_waddr != REG_ZERO);

   always_ff @(posedge hclk) begin
      if (hrst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end else if (wr_en) begin
         regs[bus.reg_waddr] <= bus.reg_wdata;
      end
   end

   assign ren[0]   = bus.reg_ren_1;
   assign ren[1]   = bus.reg_ren_2;
   assign raddr[0] = bus.reg_raddr_1;
   assign raddr[1] = bus.reg_raddr_2;

   for (genvar p = 0; p < NPORT; p++) begin : g_rport
      assign rfile_data[p] = regs[raddr[p]];

      swc_regfile_rport #(.XLEN(XLEN)) u_rport (
         .hclk       (hclk),
         .hrst       (hrst),
         .ren        (ren[p]),
         .raddr      (raddr[p]),
         .rfile_data (rfile_data[p]),
         .wr_en      (wr_en),
         .waddr      (bus.reg_waddr),
         .wdata      (bus.reg_wdata),
         .rdata      (rdata[p]),
         .rvalid     (rvalid[p])
      );
   end

   assign bus.reg_rdata_1  = rdata[0];
   assign bus.reg_rvalid_1 = rvalid[0];
   assign bus.reg_rdata_2  = rdata[1];
   assign bus.reg_rvalid_2 = rvalid[1];
endmodule

// File: tb/tb_swc_regfile.sv
// Directed bench for swc_regfile: reset values, write/read, x0, bypass,
// floating bus and reset-vs-write collision.
module tb_swc_regfile;
   logic hclk = 1'b0;
   logic hrst = 1'b0;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   swc_regfile_if #(.XLEN(32)) bus ();

   swc_regfile #(.NREG(32), .XLEN(32), .SP_INIT(32'h0000_1000)) dut (
      .hclk (hclk),
      .hrst (hrst),
      .bus  (bus)
   );

   always #5 hclk = ~hclk;

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle();
      bus.reg_wen   = 1'b0;
      bus.reg_waddr = 5'd0;
      bus.reg_wdata = 32'h0;
      bus.reg_ren_1 = 1'b0;
      bus.reg_ren_2 = 1'b0;
      bus.reg_raddr_1 = 5'd0;
      bus.reg_raddr_2 = 5'd0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.reg_wen = 1'b1; bus.reg_waddr = a; bus.reg_wdata = d;
   endtask

   task automatic test_reset();
      idle();
      hrst = 1'b1;
      tick(); tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata1 got=%h exp=%h", bus.reg_rdata_1, 32'h0); end
      vec_cnt++; if (bus.reg_rvalid_1 !== 1'b0) begin err_cnt++; $display("FAIL rst_rvalid1 got=%b exp=0", bus.reg_rvalid_1); end
      vec_cnt++; if (bus.reg_rdata_2 !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata2 got=%h exp=%h", bus.reg_rdata_2, 32'h0); end
      vec_cnt++; if (bus.reg_rvalid_2 !== 1'b0) begin err_cnt++; $display("FAIL rst_rvalid2 got=%b exp=0", bus.reg_rvalid_2); end
      hrst = 1'b0;
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd2;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0000_1000) begin err_cnt++; $display("FAIL sp_init got=%h exp=%h", bus.reg_rdata_1, 32'h0000_1000); end
      vec_cnt++; if (bus.reg_rvalid_1 !== 1'b1) begin err_cnt++; $display("FAIL sp_rvalid got=%b exp=1", bus.reg_rvalid_1); end
      bus.reg_raddr_1 = 5'd5;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0) begin err_cnt++; $display("FAIL x5_reset got=%h exp=%h", bus.reg_rdata_1, 32'h0); end
      idle();
      tick();
      vec_cnt++; if (bus.reg_rvalid_1 !== 1'b0) begin err_cnt++; $display("FAIL rvalid_drop got=%b exp=0", bus.reg_rvalid_1); end
   endtask

   task automatic test_write_read();
      wr(5'd5, 32'hDEAD_BEEF);
      tick();
      idle();
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd5;
      bus.reg_ren_2 = 1'b1; bus.reg_raddr_2 = 5'd5;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL wr_rd1 got=%h exp=%h", bus.reg_rdata_1, 32'hDEAD_BEEF); end
      vec_cnt++; if (bus.reg_rdata_2 !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL wr_rd2 got=%h exp=%h", bus.reg_rdata_2, 32'hDEAD_BEEF); end
      vec_cnt++; if ({bus.reg_rvalid_1, bus.reg_rvalid_2} !== 2'b11) begin err_cnt++; $display("FAIL wr_rvalid got=%b%b exp=11", bus.reg_rvalid_1, bus.reg_rvalid_2); end
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         vec_cnt++; if ({bus.reg_rvalid_1, bus.reg_rvalid_2} !== 2'b00) begin err_cnt++; $display("FAIL hold_rvalid[%0d] got=%b%b exp=00", i, bus.reg_rvalid_1, bus.reg_rvalid_2); end
         vec_cnt++; if (bus.reg_rdata_1 !== 32'hDEAD_BEEF || bus.reg_rdata_2 !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL hold_data[%0d] got=%h/%h exp=%h", i, bus.reg_rdata_1, bus.reg_rdata_2, 32'hDEAD_BEEF); end
      end
   endtask

   task automatic test_x0();
      wr(5'd0, 32'hFFFF_FFFF);
      tick();
      idle();
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd0;
      bus.reg_ren_2 = 1'b1; bus.reg_raddr_2 = 5'd5;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0) begin err_cnt++; $display("FAIL x0_read got=%h exp=%h", bus.reg_rdata_1, 32'h0); end
      vec_cnt++; if (bus.reg_rdata_2 !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL x0_side got=%h exp=%h", bus.reg_rdata_2, 32'hDEAD_BEEF); end
      // x0 write on the same edge as an x0 read must not bypass
      wr(5'd0, 32'h1234_5678);
      bus.reg_ren_2 = 1'b0;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0) begin err_cnt++; $display("FAIL x0_bypass got=%h exp=%h", bus.reg_rdata_1, 32'h0); end
      idle();
      tick();
   endtask

   task automatic test_bypass();
      wr(5'd7, 32'h0000_0005);
      tick();
      idle();
      bus.reg_ren_2 = 1'b1; bus.reg_raddr_2 = 5'd7;
      tick();
      vec_cnt++; if (bus.reg_rdata_2 !== 32'h0000_0005) begin err_cnt++; $display("FAIL byp_old got=%h exp=%h", bus.reg_rdata_2, 32'h5); end
      idle();
      wr(5'd7, 32'h0000_0123);
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd7;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0000_0123) begin err_cnt++; $display("FAIL byp_same got=%h exp=%h", bus.reg_rdata_1, 32'h123); end
      bus.reg_wen = 1'b0;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0000_0123) begin err_cnt++; $display("FAIL byp_after got=%h exp=%h", bus.reg_rdata_1, 32'h123); end
      idle();
   endtask

   task automatic test_float();
      wr(5'd3, 32'hA5A5_A5A5);
      tick();
      idle();
      bus.reg_wen = 1'bz; bus.reg_wdata = 32'hzzzz_zzzz; bus.reg_waddr = 5'bzzzzz;
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         vec_cnt++; if (bus.reg_rdata_1 !== 32'hA5A5_A5A5) begin err_cnt++; $display("FAIL float[%0d] got=%h exp=%h", i, bus.reg_rdata_1, 32'hA5A5_A5A5); end
      end
      idle();
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd5;
      bus.reg_ren_2 = 1'b1; bus.reg_raddr_2 = 5'd3;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'hDEAD_BEEF || bus.reg_rdata_2 !== 32'hA5A5_A5A5) begin err_cnt++; $display("FAIL indep got=%h/%h exp=%h/%h", bus.reg_rdata_1, bus.reg_rdata_2, 32'hDEAD_BEEF, 32'hA5A5_A5A5); end
      idle();
   endtask

   task automatic test_reset_collision();
      wr(5'd4, 32'h0000_0001);
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd4;
      hrst = 1'b1;
      tick();
      hrst = 1'b0;
      idle();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0) begin err_cnt++; $display("FAIL rc_rdata got=%h exp=%h", bus.reg_rdata_1, 32'h0); end
      vec_cnt++; if (bus.reg_rvalid_1 !== 1'b0) begin err_cnt++; $display("FAIL rc_rvalid got=%b exp=0", bus.reg_rvalid_1); end
      bus.reg_ren_1 = 1'b1; bus.reg_raddr_1 = 5'd4;
      bus.reg_ren_2 = 1'b1; bus.reg_raddr_2 = 5'd5;
      tick();
      vec_cnt++; if (bus.reg_rdata_1 !== 32'h0) begin err_cnt++; $display("FAIL rc_x4 got=%h exp=%h", bus.reg_rdata_1, 32'h0); end
      vec_cnt++; if (bus.reg_rdata_2 !== 32'h0) begin err_cnt++; $display("FAIL rc_x5 got=%h exp=%h", bus.reg_rdata_2, 32'h0); end
      idle();
      tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_float();
      test_reset_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
endmodule
